// File: rtl/dcache_ctrl_if.sv
// Core-side and memory-side handshake bundle for dcache_ctrl.
// Latency: n/a (wires only).
// Backpressure: the core is held by o_stall; the memory completes each beat with i_mem_ack.
// Signal names keep the cache's own point of view (i_ = into cache, o_ = out of cache).
// Modports: slave = cache side, master = core/memory side.
`timescale 1ns/1ps
interface dcache_ctrl_if #(
    parameter int BUS_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 10
);
    // core side
    logic                      i_rd_en;
    logic                      i_wr_en;
    logic [MEM_ADDR_WIDTH-1:0] i_addr;
    logic [BUS_WIDTH-1:0]      i_wdata;
    logic [BUS_WIDTH-1:0]      o_rdata;
    logic                      o_stall;
    // memory side
    logic                      o_mem_req;
    logic                      o_mem_we;
    logic [MEM_ADDR_WIDTH-1:0] o_mem_addr;
    logic [BUS_WIDTH-1:0]      o_mem_wdata;
    logic                      i_mem_ack;
    logic [BUS_WIDTH-1:0]      i_mem_rdata;

    modport slave (
        input  i_rd_en, i_wr_en, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
        output o_rdata, o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_rd_en, i_wr_en, i_addr, i_wdata, i_mem_ack, i_mem_rdata,
        input  o_rdata, o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through / no-write-allocate data cache controller.
// Latency: read hit is combinational (0 cycles); a miss costs 1 + WORDS_PER_BLOCK beats; a store holds until the memory ack.
// Backpressure: o_stall holds the core during refills and stores; memory paces each beat with i_mem_ack.
//
// Ports: i_clk, i_aresetn (async active-low); bus (dcache_ctrl_if.slave) carries the core
// load/store request, o_rdata/o_stall, and the single-beat memory request/ack channel.
// Optional build macro DCACHE_PERF_CNT_EN adds saturating 32-bit o_hit_cnt / o_miss_cnt.
`timescale 1ns/1ps
module dcache_ctrl #(
    parameter int BUS_WIDTH       = 32,
    parameter int INDEX_SIZE      = 5,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int MEM_ADDR_WIDTH  = 10
) (
    input  logic               i_clk,
    input  logic               i_aresetn,
    dcache_ctrl_if.slave       bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]        o_hit_cnt,
    output logic [31:0]        o_miss_cnt
`endif
);

    localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK);
    localparam int TAG_SIZE = MEM_ADDR_WIDTH - INDEX_SIZE - OFFSET_W;
    localparam int LINES    = 1 << INDEX_SIZE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t                    state_q;
    logic [OFFSET_W-1:0]       beat_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0]      wdata_q;
    logic [LINES-1:0]          valid_q;
    logic                      mem_req_q;
    logic                      mem_we_q;

    // Tag and data arrays carry no reset; valid_q alone qualifies their contents.
    logic [TAG_SIZE-1:0]       tag_mem  [LINES];
    logic [BUS_WIDTH-1:0]      data_mem [LINES][WORDS_PER_BLOCK];

    // Live request fields
    logic [TAG_SIZE-1:0]       req_tag;
    logic [INDEX_SIZE-1:0]     req_index;
    logic [OFFSET_W-1:0]       req_off;
    // Latched request fields
    logic [TAG_SIZE-1:0]       lat_tag;
    logic [INDEX_SIZE-1:0]     lat_index;
    logic [OFFSET_W-1:0]       lat_off;

    assign req_tag   = bus.i_addr[MEM_ADDR_WIDTH-1 -: TAG_SIZE];
    assign req_index = bus.i_addr[OFFSET_W +: INDEX_SIZE];
    assign req_off   = bus.i_addr[OFFSET_W-1:0];
    assign lat_tag   = addr_q[MEM_ADDR_WIDTH-1 -: TAG_SIZE];
    assign lat_index = addr_q[OFFSET_W +: INDEX_SIZE];
    assign lat_off   = addr_q[OFFSET_W-1:0];

    logic req_hit;
    logic lat_hit;
    logic rd_hit_idle;
    logic rd_miss_idle;
    logic last_beat;

    assign req_hit      = valid_q[req_index] && (tag_mem[req_index] == req_tag);
    assign lat_hit      = valid_q[lat_index] && (tag_mem[lat_index] == lat_tag);
    // A store in the same cycle wins, so the load is only considered when i_wr_en is low.
    assign rd_hit_idle  = (state_q == IDLE) && !bus.i_wr_en && bus.i_rd_en &&  req_hit;
    assign rd_miss_idle = (state_q == IDLE) && !bus.i_wr_en && bus.i_rd_en && !req_hit;
    assign last_beat    = &beat_q;

    // Core-facing outputs are combinational so a hit returns data in the request cycle.
    always_comb begin
        logic stall;
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = bus.i_wr_en || rd_miss_idle;
            REFILL:  stall = 1'b1;
            WRITE:   stall = !bus.i_mem_ack;  // release the core on the ack cycle itself
            default: stall = 1'b0;
        endcase
        // Stall must drop the moment reset is applied, not at the next edge.
        bus.o_stall = stall && i_aresetn;
        bus.o_rdata = rd_hit_idle ? data_mem[req_index][req_off] : '0;
    end

    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = (state_q == REFILL) ? {lat_tag, lat_index, beat_q} : addr_q;
    assign bus.o_mem_wdata = wdata_q;

    // Control FSM with registered memory request qualifiers.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            valid_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_wr_en) begin
                        addr_q    <= bus.i_addr;
                        wdata_q   <= bus.i_wdata;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        state_q   <= WRITE;
                    end else if (rd_miss_idle) begin
                        addr_q    <= bus.i_addr;
                        beat_q    <= '0;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        state_q   <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.i_mem_ack) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            valid_q[lat_index] <= 1'b1;
                            mem_req_q          <= 1'b0;
                            state_q            <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.i_mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Array updates: refill beats fill the line; a store updates the line only if it is resident.
    always_ff @(posedge i_clk) begin
        if (state_q == REFILL && bus.i_mem_ack) begin
            data_mem[lat_index][beat_q] <= bus.i_mem_rdata;
            if (last_beat) begin
                tag_mem[lat_index] <= lat_tag;
            end
        end
        if (state_q == WRITE && bus.i_mem_ack && lat_hit) begin
            data_mem[lat_index][lat_off] <= wdata_q;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] hit_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;

    // Saturating event counters; a held load that hits counts once per cycle it is presented.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rd_hit_idle && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (rd_miss_idle && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a memory responder and scoreboard queues.
// Latency: n/a.
// Backpressure: memory ack delay is programmable per transaction.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_ctrl_if #(.BUS_WIDTH(32), .MEM_ADDR_WIDTH(10)) bus ();

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl #(
        .BUS_WIDTH      (32),
        .INDEX_SIZE     (5),
        .WORDS_PER_BLOCK(4),
        .MEM_ADDR_WIDTH (10)
    ) dut (
        .i_clk     (clk),
        .i_aresetn (arst_n),
        .bus       (bus)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .o_hit_cnt (hit_cnt),
        .o_miss_cnt(miss_cnt)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] rd_q[$];

    int tests = 0;
    int fails = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;
    int beats     = 0;
    int stalls    = 0;
    int req_cycles = 0;
    bit done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // One clock cycle: starts just after a falling edge with core inputs already applied,
    // plays the memory, checks the core response, and ends at the next falling edge.
    task automatic step();
        logic [31:0] exp_rd;
        bus.i_mem_ack = 1'b0;
        #1;
        if (bus.o_mem_req) begin
            req_cycles++;
            if (mem_q.size() == 0) begin
                chk("unexpected_mem_req", 1, 0);
            end else begin
                chk("mem_we", bus.o_mem_we, mem_q[0].we);
                chk("mem_addr", bus.o_mem_addr, mem_q[0].addr);
                if (mem_q[0].we) chk("mem_wdata", bus.o_mem_wdata, mem_q[0].data);
                if (wait_cnt >= ack_delay) begin
                    bus.i_mem_ack   = 1'b1;
                    bus.i_mem_rdata = 32'h100 + 32'(bus.o_mem_addr);
                    void'(mem_q.pop_front());
                    wait_cnt = 0;
                    beats++;
                end else begin
                    wait_cnt++;
                end
            end
        end
        #1;
        if (bus.o_stall) stalls++;
        if ((bus.i_rd_en || bus.i_wr_en) && !bus.o_stall) begin
            done = 1'b1;
            if (bus.i_rd_en && !bus.i_wr_en) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rdata", 1, 0);
                end else begin
                    exp_rd = rd_q.pop_front();
                    chk("rdata", bus.o_rdata, exp_rd);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run_txn(input string nm, input int exp_stalls, input int exp_beats, input int exp_req);
        int cyc;
        cyc = 0;
        done = 1'b0; stalls = 0; beats = 0; req_cycles = 0; wait_cnt = 0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        chk({nm, "_done"}, done, 1);
        chk({nm, "_stalls"}, stalls, exp_stalls);
        chk({nm, "_beats"}, beats, exp_beats);
        chk({nm, "_req_cycles"}, req_cycles, exp_req);
        chk({nm, "_memq_left"}, mem_q.size(), 0);
    endtask

    task automatic do_read(input string nm, input logic [9:0] a, input logic [31:0] exp, input int nbeats);
        mem_txn_t t;
        bus.i_addr  = a;
        bus.i_rd_en = 1'b1;
        rd_q.push_back(exp);
        for (int k = 0; k < nbeats; k++) begin
            t.we = 1'b0; t.addr = {a[9:2], 2'(k)}; t.data = '0;
            mem_q.push_back(t);
        end
        ack_delay = 0;
        run_txn(nm, (nbeats > 0) ? nbeats + 1 : 0, nbeats, nbeats);
    endtask

    task automatic do_write(input string nm, input logic [9:0] a, input logic [31:0] d, input int delay);
        mem_txn_t t;
        bus.i_addr  = a;
        bus.i_wdata = d;
        bus.i_wr_en = 1'b1;
        t.we = 1'b1; t.addr = a; t.data = d;
        mem_q.push_back(t);
        ack_delay = delay;
        run_txn(nm, delay + 1, 1, delay + 1);
    endtask

    task automatic idle_chk(input string nm);
        #1;
        chk({nm, "_stall"}, bus.o_stall, 0);
        chk({nm, "_mem_req"}, bus.o_mem_req, 0);
        chk({nm, "_rdata"}, bus.o_rdata, 0);
    endtask

    initial begin
        mem_txn_t t;
        int cyc;
        bus.i_rd_en = 1'b0; bus.i_wr_en = 1'b0;
        bus.i_addr = '0; bus.i_wdata = '0;
        bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_stall", bus.o_stall, 0);
        chk("rst_mem_req", bus.o_mem_req, 0);
        chk("rst_mem_we", bus.o_mem_we, 0);
        chk("rst_rdata", bus.o_rdata, 0);
        arst_n = 1'b1;
        idle_chk("post_rst");

        // A stray ack while idle must not start anything
        bus.i_mem_ack = 1'b1;
        #1 chk("idle_ack_req", bus.o_mem_req, 0);
        @(negedge clk);
        bus.i_mem_ack = 1'b0;
        idle_chk("idle_ack_after");

        // Cold miss: 4 beats, 5 stall cycles, then the held load hits
        do_read("miss_0a5", 10'h0A5, 32'h1A5, 4);
        idle_chk("after_miss");

        // Hit in the same line
        do_read("hit_0a6", 10'h0A6, 32'h1A6, 0);
`ifdef DCACHE_PERF_CNT_EN
        chk("perf_miss_cnt", miss_cnt, 1);
        chk("perf_hit_cnt", hit_cnt, 2);
`endif

        // Store hit with a slow memory; line updated
        do_write("wr_hit_0a6", 10'h0A6, 32'hDEAD_BEEF, 3);
        do_read("rd_after_wr", 10'h0A6, 32'hDEAD_BEEF, 0);

        // Store miss: memory only, no allocation
        do_write("wr_miss_3e0", 10'h3E0, 32'h1234_5678, 0);
        do_read("rd_3e0_refill", 10'h3E0, 32'h4E0, 4);
        do_read("rd_0a5_still", 10'h0A5, 32'h1A5, 0);

        // Reset in the middle of a refill
        bus.i_addr  = 10'h155;
        bus.i_rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t.we = 1'b0; t.addr = {8'h55, 2'(k)}; t.data = '0;
            mem_q.push_back(t);
        end
        ack_delay = 0; beats = 0; wait_cnt = 0; cyc = 0; done = 1'b0;
        while (beats < 3 && cyc < 20) begin
            step();
            cyc++;
        end
        bus.i_mem_ack = 1'b0;
        chk("mid_refill_beats", beats, 3);
        #1;
        chk("mid_refill_req", bus.o_mem_req, 1);
        chk("mid_refill_addr", bus.o_mem_addr, 10'h157);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_req", bus.o_mem_req, 0);
        chk("mid_rst_we", bus.o_mem_we, 0);
        chk("mid_rst_stall", bus.o_stall, 0);
        bus.i_rd_en = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        do_read("rd_155_after_rst", 10'h155, 32'h255, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter BUS_WIDTH, 32, data word width in bits.
REQ-002 Parameter INDEX_SIZE, 5, line index bits; cache holds 2**INDEX_SIZE lines.
REQ-003 Parameter WORDS_PER_BLOCK, 4, words per line; power of two, at least 2.
REQ-004 Parameter MEM_ADDR_WIDTH, 10, word-address width; TAG_SIZE = MEM_ADDR_WIDTH - INDEX_SIZE - log2(WORDS_PER_BLOCK), 3 at defaults, at least 1.
REQ-005 i_clk  in  1  clock; all state changes on the rising edge.
REQ-006 i_aresetn  in  1  asynchronous active-low reset.
REQ-007 i_rd_en  in  1  core load request.
REQ-008 i_wr_en  in  1  core store request.
REQ-009 i_addr  in  MEM_ADDR_WIDTH  word address, split {tag, index, offset}.
REQ-010 i_wdata  in  BUS_WIDTH  store data.
REQ-011 o_rdata  out  BUS_WIDTH  load data; combinational on a hit.
REQ-012 o_stall  out  1  core hold; combinational.
REQ-013 o_mem_req, o_mem_we  out  1 each  memory request and write qualifier.
REQ-014 o_mem_addr  out  MEM_ADDR_WIDTH; o_mem_wdata  out  BUS_WIDTH.
REQ-015 i_mem_ack  in  1; i_mem_rdata  in  BUS_WIDTH  one-beat completion and read data.

Function
REQ-016 The FSM SHALL have three states: IDLE, REFILL and WRITE.
REQ-017 A hit is valid[index] AND tag_store[index] == tag.
REQ-018 IDLE, i_wr_en=1: o_stall=1, next state WRITE; i_rd_en is ignored in that cycle (write priority).
REQ-019 IDLE, i_rd_en=1, hit: o_rdata = line[index][offset] in the same cycle, o_stall=0, no state change.
REQ-020 IDLE, i_rd_en=1, miss: o_stall=1, next state REFILL, beat counter cleared to 0, request address latched.
REQ-021 REFILL: o_mem_req=1, o_mem_we=0, o_mem_addr={latched tag, latched index, beat}.
REQ-022 On each i_mem_ack in REFILL, i_mem_rdata SHALL be written to word "beat" and beat SHALL increment.
REQ-023 On the ack of beat WORDS_PER_BLOCK-1, valid and tag SHALL be set and the next state SHALL be IDLE; the held load then hits.
REQ-024 o_stall SHALL remain 1 for every REFILL cycle.
REQ-025 WRITE policy: write-through, no-write-allocate.
REQ-026 WRITE: o_mem_req=1, o_mem_we=1, o_mem_addr and o_mem_wdata taken from latched i_addr and i_wdata, held stable until i_mem_ack.
REQ-027 On i_mem_ack in WRITE: o_stall=0 in that cycle, the cached word is updated only on a hit, and the next state is IDLE.
REQ-028 o_mem_req SHALL be 0 in IDLE; i_mem_ack in IDLE SHALL be ignored.
REQ-029 With no request, o_rdata SHALL be 0.

Reset
REQ-030 Asserting i_aresetn low, including mid-REFILL or mid-WRITE, SHALL immediately force IDLE, clear all valid bits and the beat counter, and drive o_stall, o_mem_req and o_mem_we to 0.
REQ-031 Data and tag arrays SHALL NOT be reset.

Configuration
REQ-032 Macro DCACHE_PERF_CNT_EN defined: add outputs o_hit_cnt and o_miss_cnt, each 32 bits, reset to 0.
REQ-033 o_hit_cnt SHALL increment on each IDLE read hit; o_miss_cnt SHALL increment on each IDLE read miss; both saturate at 0xFFFFFFFF.
REQ-034 Macro DCACHE_PERF_CNT_EN undefined: these ports and counters SHALL be absent, with all other behaviour unchanged.

Verification
REQ-035 Reset, then read 0x0A5 with mem returning 0x100+addr and ack every cycle -> 4 beats at 0x0A4..0x0A7, stall for 5 cycles, then o_rdata=0x1A5 with stall 0.
REQ-036 Read 0x0A6 after REQ-035 -> hit, o_rdata=0x1A6 the same cycle, no o_mem_req.
REQ-037 Write 0x0A6=0xDEADBEEF, ack delayed 3 cycles -> address and data stable 4 cycles, stall low on the ack cycle; a later read of 0x0A6 returns 0xDEADBEEF.
REQ-038 Write to 0x3E0 (miss) -> memory write only, valid[index 0x18] stays 0; a later read of 0x3E0 triggers a refill.
REQ-039 Reset asserted after beat 2 of a refill -> o_mem_req=0 at once; after release, a read of the same address triggers a full 4-beat refill.
REQ-040 DCACHE_PERF_CNT_EN defined, run REQ-035 to REQ-036 -> o_miss_cnt=1, o_hit_cnt=2 (post-refill hit plus REQ-036).
